// File: rtl/wr_arb_pkg.sv
// rtl/wr_arb_pkg.sv - shared types and sizing helpers for the write-port arbiter
package wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEFAULT    = 4;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int REQ_IDX_W          = $clog2(NUM_REQ_DEFAULT);

    // Keeps a usable 1-bit index even for degenerate requester counts.
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// rtl/wr_port_arbiter_if.sv - requester and FIFO write-port signals of the arbiter
interface wr_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            i_req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          i_wfull;
    logic                          o_winc;
    logic [DATA_WIDTH-1:0]         o_wdata;
    logic [NUM_REQ-1:0]            o_grant;
    logic                          o_busy;

    modport slave (
        input  i_req_valid, i_req_last, i_req_data, i_wfull,
        output o_req_ready, o_winc, o_wdata, o_grant, o_busy
    );

    modport master (
        output i_req_valid, i_req_last, i_req_data, i_wfull,
        input  o_req_ready, o_winc, o_wdata, o_grant, o_busy
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting after last_owner
module rr_picker
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic [NUM_REQ-1:0] rotated;
    int                 start;
    int                 offset;
    int                 src;
    int                 abs_idx;

    always_comb begin
        start = (int'(last_owner) >= NUM_REQ - 1) ? 0 : int'(last_owner) + 1;

        // Rotate so bit 0 is the highest-priority requester this round.
        rotated = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src = start + i;
            if (src >= NUM_REQ) begin
                src = src - NUM_REQ;
            end
            rotated[i] = req[IDX_W'(src)];
        end

        pick_valid = 1'b0;
        offset     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset     = i;
                pick_valid = 1'b1;
            end
        end

        abs_idx = start + offset;
        if (abs_idx >= NUM_REQ) begin
            abs_idx = abs_idx - NUM_REQ;
        end
        pick_idx = IDX_W'(abs_idx);
        pick     = pick_valid ? (NUM_REQ'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - packet-atomic round-robin owner of the async FIFO write port
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic               i_wclk,
    input  logic               i_wrst,
    wr_port_arbiter_if.slave   bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  winc;
    logic                  busy;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (bus.i_req_valid),
        .last_owner (last_owner_q),
        .pick       (pick_onehot),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Owner slice is muxed even while idle so o_wdata never floats.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_valid = bus.i_req_valid[k];
                owner_last  = bus.i_req_last[k];
                owner_data  = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        req_ready    = '0;
        winc         = 1'b0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    state_d = PKT;
                end
            end
            PKT: begin
                busy      = 1'b1;
                req_ready = bus.i_wfull ? '0 : grant_q;
                winc      = owner_valid & ~bus.i_wfull;
                if (winc && owner_last) begin
                    last_owner_d = owner_q;
                    grant_d      = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.o_req_ready = req_ready;
    assign bus.o_winc      = winc;
    assign bus.o_wdata     = owner_data;
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = busy;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - self-checking bench for wr_port_arbiter
module tb_wr_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic i_wclk = 1'b0;
    logic i_wrst = 1'b1;

    always #5 i_wclk = ~i_wclk;

    wr_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    wr_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .i_wclk (i_wclk),
        .i_wrst (i_wrst),
        .bus    (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Pending beats per requester: bit 8 = last, bits 7:0 = data.
    logic [8:0] pq [NR][$];
    logic       hold [NR];
    logic       wfull_drv;

    int m_owner;
    int m_last;
    logic [7:0] m_writes[$];
    logic [7:0] d_writes[$];

    logic [NR-1:0] h_grant[$];
    logic [NR-1:0] h_ready[$];
    logic          h_winc[$];
    logic          h_busy[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
    endtask

    task automatic clear_all();
        for (int r = 0; r < NR; r++) begin
            pq[r].delete();
            hold[r] = 1'b0;
        end
        wfull_drv = 1'b0;
        m_writes.delete();
        d_writes.delete();
        h_grant.delete();
        h_ready.delete();
        h_winc.delete();
        h_busy.delete();
    endtask

    task automatic drive_inputs();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        for (int r = 0; r < NR; r++) begin
            if (pq[r].size() > 0 && !hold[r]) begin
                v[r]          = 1'b1;
                l[r]          = pq[r][0][8];
                d[r*DW +: DW] = pq[r][0][7:0];
            end else begin
                v[r]          = 1'b0;
                l[r]          = 1'b0;
                d[r*DW +: DW] = 8'($urandom);
            end
        end
        bus.i_req_valid = v;
        bus.i_req_last  = l;
        bus.i_req_data  = d;
        bus.i_wfull     = wfull_drv;
    endtask

    // Reference: an owner holds the port until its last beat; idle picks next valid after m_last.
    task automatic compare_and_advance();
        logic [NR-1:0] eg;
        logic [NR-1:0] er;
        logic          ew;
        bit            found;
        eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
        ew = (m_owner >= 0) && bus.i_req_valid[m_owner] && !bus.i_wfull;
        er = (m_owner >= 0 && !bus.i_wfull) ? eg : '0;
        chk("grant", 32'(bus.o_grant), 32'(eg));
        chk("ready", 32'(bus.o_req_ready), 32'(er));
        chk("winc", 32'(bus.o_winc), 32'(ew));
        chk("busy", 32'(bus.o_busy), 32'(m_owner >= 0));
        if (m_owner >= 0)
            chk("wdata", 32'(bus.o_wdata), 32'(bus.i_req_data[m_owner*DW +: DW]));
        h_grant.push_back(bus.o_grant);
        h_ready.push_back(bus.o_req_ready);
        h_winc.push_back(bus.o_winc);
        h_busy.push_back(bus.o_busy);
        if (bus.o_winc === 1'b1) d_writes.push_back(bus.o_wdata);

        if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                if (!found && bus.i_req_valid[(m_last + i) % NR]) begin
                    m_owner = (m_last + i) % NR;
                    found   = 1'b1;
                end
            end
        end else if (ew) begin
            m_writes.push_back(bus.i_req_data[m_owner*DW +: DW]);
            void'(pq[m_owner].pop_front());
            if (bus.i_req_last[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle();
        drive_inputs();
        @(negedge i_wclk);
        compare_and_advance();
        @(posedge i_wclk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NR; r++) if (pq[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int max_cycles);
        int c = 0;
        for (int r = 0; r < NR; r++) hold[r] = 1'b0;
        wfull_drv = 1'b0;
        while ((!all_empty() || m_owner >= 0) && c < max_cycles) begin
            cycle();
            c++;
        end
        chk("drain_done", 32'(all_empty()), 32'd1);
    endtask

    task automatic expect_writes(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_count"}, 32'(d_writes.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < d_writes.size(); i++)
            chk(tag, 32'(d_writes[i]), 32'(exp[i]));
    endtask

    task automatic push_pkt(input int r, input logic [7:0] first, input int len);
        for (int b = 0; b < len; b++)
            pq[r].push_back({(b == len - 1), first + 8'(b)});
    endtask

    task automatic do_reset();
        i_wrst = 1'b1;
        clear_all();
        model_reset();
        drive_inputs();
        @(posedge i_wclk);
        #1;
        i_wrst = 1'b0;
    endtask

    initial begin
        clear_all();
        model_reset();
        drive_inputs();

        // Reset values
        #2;
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_winc", 32'(bus.o_winc), 32'd0);
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_wdata", 32'(bus.o_wdata), 32'(bus.i_req_data[DW-1:0]));
        do_reset();

        // Requester 2 alone, 3-beat packet
        push_pkt(2, 8'h10, 3);
        run(5);
        chk("t1_idle_grant", 32'(h_grant[0]), 32'd0);
        chk("t1_idle_winc", 32'(h_winc[0]), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            chk("t1_grant", 32'(h_grant[i]), 32'b0100);
            chk("t1_winc", 32'(h_winc[i]), 32'd1);
        end
        chk("t1_after_busy", 32'(h_busy[4]), 32'd0);
        chk("t1_after_grant", 32'(h_grant[4]), 32'd0);
        expect_writes("t1_data", '{8'h10, 8'h11, 8'h12});

        // All four continuously valid with single-beat packets
        do_reset();
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < 3; p++) push_pkt(r, 8'h50 + 8'(r), 1);
        run(12);
        for (int i = 0; i < 12; i++)
            chk("t2_winc_pattern", 32'(h_winc[i]), 32'(i % 2));
        expect_writes("t2_order", '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50, 8'h51});
        drain(100);

        // Full stall mid-packet on requester 1
        do_reset();
        push_pkt(1, 8'h20, 4);
        run(2);
        wfull_drv = 1'b1;
        run(5);
        wfull_drv = 1'b0;
        run(4);
        for (int i = 2; i <= 6; i++) begin
            chk("t3_full_winc", 32'(h_winc[i]), 32'd0);
            chk("t3_full_ready", 32'(h_ready[i]), 32'd0);
            chk("t3_full_grant", 32'(h_grant[i]), 32'b0010);
        end
        chk("t3_resume", 32'(h_winc[7]), 32'd1);
        expect_writes("t3_data", '{8'h20, 8'h21, 8'h22, 8'h23});

        // Owner 0 drops valid for 3 cycles while requester 3 waits
        do_reset();
        push_pkt(0, 8'h30, 4);
        push_pkt(3, 8'h40, 2);
        run(2);
        hold[0] = 1'b1;
        run(3);
        hold[0] = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk("t4_hold_grant", 32'(h_grant[i]), 32'b0001);
            chk("t4_hold_ready3", 32'(h_ready[i][3]), 32'd0);
            chk("t4_hold_winc", 32'(h_winc[i]), 32'd0);
        end
        drain(40);
        expect_writes("t4_data", '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41});

        // Asynchronous reset mid-packet
        do_reset();
        push_pkt(1, 8'h60, 5);
        run(3);
        #3;
        chk("t5_pre_busy", 32'(bus.o_busy), 32'd1);
        i_wrst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(bus.o_grant), 32'd0);
        chk("t5_async_busy", 32'(bus.o_busy), 32'd0);
        chk("t5_async_winc", 32'(bus.o_winc), 32'd0);
        chk("t5_async_ready", 32'(bus.o_req_ready), 32'd0);
        chk("t5_async_wdata", 32'(bus.o_wdata), 32'(bus.i_req_data[DW-1:0]));
        clear_all();
        model_reset();
        drive_inputs();
        @(posedge i_wclk);
        #1;
        i_wrst = 1'b0;
        push_pkt(0, 8'h70, 1);
        push_pkt(3, 8'h71, 1);
        run(5);
        chk("t5_first_grant", 32'(h_grant[1]), 32'b0001);
        expect_writes("t5_data", '{8'h70, 8'h71});

        // Randomized traffic with stalls and valid gaps
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (pq[r].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(r, 8'($urandom), $urandom_range(1, 4));
                hold[r] = ($urandom_range(0, 7) == 0);
            end
            wfull_drv = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain(200);
        expect_writes("rand_data", m_writes);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
